dmem_sram_bridge: RTL and testbench
===================================

# dmem_sram_bridge

Data-memory bridge between the core's memory-stage data port and an SRAM-like request/handshake bus. It sits directly downstream of the core's byte-strobe data port: memory-stage enable, byte strobes, ALU address and aligned write data. Each core access becomes one bus transaction (request, address-accept, data-return). While the transaction is outstanding, the bridge holds a stall request to the core pipeline.

## Interface
Parameters:
- none; widths are fixed by the 32-bit core

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- memen  in  1  core memory-stage access enable
- memwrite  in  4  byte write strobes; 0000 = load
- addr  in  32  memory-stage data address
- wdata  in  32  lane-aligned write data
- flush  in  1  memory-stage flush/exception; suppresses issue of the current access
- rdata  out  32  load data, valid in DONE
- stall  out  1  combinational stall request to the core
- req  out  1  bus request
- wr  out  1  bus write (1) / read (0)
- size  out  2  0 = byte, 1 = half, 2 = word
- baddr  out  32  bus address
- bwdata  out  32  bus write data
- bstrb  out  4  bus byte strobes
- addr_ok  in  1  request accepted this cycle
- data_ok  in  1  data returned / write complete this cycle
- brdata  in  32  bus read data, valid with data_ok

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: if memen & ~flush, latch the following, then go to REQ; otherwise stay:
  - addr → baddr
  - wdata → bwdata
  - memwrite → bstrb
  - wr = |memwrite
  - size
- Loads (memwrite = 0000) are issued with size = 2; the core extracts lanes.
- Size from strobes:
  - 1111 → 2
  - 0011 or 1100 → 1
  - single-hot → 0
  - any other pattern → 2
- REQ: req = 1; the latched fields are held stable until addr_ok.
  - addr_ok & data_ok → DONE
  - addr_ok only → WAIT
- WAIT: req = 0; on data_ok → DONE.
- When data_ok arrives on a read, brdata is captured into rdata.
- DONE: one cycle, then IDLE unconditionally; no new issue in DONE, even if memen is high.
- Cancel flag: flush while in REQ or WAIT sets `cancel`. The transaction still completes; a bus handshake is never abandoned.
  - On completion with cancel set, go to IDLE instead of DONE.
  - rdata is not updated and cancel is cleared.
- stall = (state==IDLE & memen & ~flush) | state==REQ | state==WAIT.
- stall = 0 in DONE and in IDLE without a valid access.
- Reset (asynchronous, any state):
  - state = IDLE, req = 0, cancel = 0
  - baddr, bwdata, rdata = 0
  - bstrb = 0, size = 0, wr = 0
  - stall then follows the IDLE equation.

## Timing
- Best case, memen seen in cycle 0:
  - req = 1 in cycle 1
  - addr_ok & data_ok in cycle 1 → DONE in cycle 2
  - stall low in cycle 2; the core advances at the end of cycle 2
  - 3 cycles per access
- Each extra cycle of addr_ok delay or addr_ok→data_ok gap adds one stall cycle.
- req is registered, never combinational from core inputs.
- data_ok in REQ without addr_ok is a bus protocol violation; it is ignored.
- rdata is held from DONE until the next read completes.
- flush and memen together in IDLE: no request, stall = 0.
- Reset mid-transaction aborts bus state locally; bus-side recovery is the bus owner's responsibility.

## Structure
- Shared package mips_bus_pkg: the following belong there, shared with the future instruction-side bridge:
  - state enum (IDLE/REQ/WAIT/DONE)
  - size constants SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2
- One combinational sub-module, strb_to_size (4-bit strobe → 2-bit size), reused by the instruction-side bridge.

## Test plan
- Load word: addr = 0x0000_0100, memwrite = 0000, addr_ok & data_ok in the first req cycle, brdata = 0xDEAD_BEEF → rdata = 0xDEAD_BEEF in DONE, stall high for 2 cycles, wr = 0, size = 2.
- Store byte: memwrite = 0100, wdata = 0x00AB_0000, addr_ok after 3 cycles, data_ok 2 cycles later → size = 0, bstrb = 0100, baddr/bwdata stable throughout REQ, stall high for 6 cycles.
- Store half: memwrite = 1100 → size = 1, wr = 1; pattern 0110 → size = 2.
- flush in the IDLE issue cycle → req never asserts, stall = 0.
- flush while in WAIT on a load → data_ok completes the transaction, FSM goes to IDLE, rdata keeps its previous value.
- Back-to-back: two loads, the second with memen high the cycle after DONE → second req two cycles after DONE. Also drive rst low while in WAIT → all outputs reset immediately (asynchronously).

Source files
------------

// File: rtl/mips_bus_pkg.sv
// Shared definitions for the core-to-SRAM-bus bridges (data side now, instruction side later).
// Holds the bridge FSM encoding and the bus transfer-size codes.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } bus_state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/strb_to_size.sv
// Maps a 4-bit byte-strobe pattern to the bus transfer size code.
// Loads (no strobes) and irregular patterns fall back to a full word.
module strb_to_size
  import mips_bus_pkg::*;
(
  input  logic [3:0] strb,
  output logic [1:0] size
);

  always_comb begin
    size = SZ_WORD;
    case (strb)
      4'b1111:                            size = SZ_WORD;
      4'b0011, 4'b1100:                   size = SZ_HALF;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SZ_BYTE;
      default:                            size = SZ_WORD;
    endcase
  end

endmodule

// File: rtl/dmem_sram_bridge.sv
// Turns each memory-stage data access into one SRAM-like bus transaction
// (request, address accept, data return), stalling the core while it is outstanding.
module dmem_sram_bridge
  import mips_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        memen,
  input  logic [3:0]  memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        req,
  output logic        wr,
  output logic [1:0]  size,
  output logic [31:0] baddr,
  output logic [31:0] bwdata,
  output logic [3:0]  bstrb,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic [31:0] brdata
);

  bus_state_t state, state_next;
  logic       cancel;
  logic       issue;
  logic       complete;
  logic       cancel_now;
  logic [1:0] size_issue;

  strb_to_size u_strb_to_size (
    .strb (memwrite),
    .size (size_issue)
  );

  assign issue      = (state == IDLE) && memen && !flush;
  assign complete   = ((state == REQ) && addr_ok && data_ok) || ((state == WAIT) && data_ok);
  // A flush arriving in the very cycle the bus finishes still cancels the result.
  assign cancel_now = cancel || flush;
  assign stall      = issue || (state == REQ) || (state == WAIT);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (issue) state_next = REQ;
      REQ: begin
        if (addr_ok) begin
          if (data_ok) state_next = cancel_now ? IDLE : DONE;
          else         state_next = WAIT;
        end
      end
      WAIT: if (data_ok) state_next = cancel_now ? IDLE : DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      req   <= 1'b0;
    end else begin
      state <= state_next;
      req   <= (state_next == REQ);
    end
  end

  // Cancel survives until the handshake finishes; the bus transaction itself is never dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cancel <= 1'b0;
    end else if (complete || (state == IDLE) || (state == DONE)) begin
      cancel <= 1'b0;
    end else if (flush) begin
      cancel <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baddr  <= 32'd0;
      bwdata <= 32'd0;
      bstrb  <= 4'd0;
      wr     <= 1'b0;
      size   <= SZ_BYTE;
    end else if (issue) begin
      baddr  <= addr;
      bwdata <= wdata;
      bstrb  <= memwrite;
      wr     <= |memwrite;
      size   <= size_issue;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= 32'd0;
    end else if (complete && !wr && !cancel_now) begin
      rdata <= brdata;
    end
  end

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Directed self-checking bench for dmem_sram_bridge: loads, stores of each size,
// flush handling, back-to-back issue and asynchronous reset mid-transaction.
module tb_dmem_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        memen;
  logic [3:0]  memwrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        flush;
  logic [31:0] rdata;
  logic        stall;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] baddr;
  logic [31:0] bwdata;
  logic [3:0]  bstrb;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] brdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_sram_bridge dut (
    .clk      (clk),
    .rst      (rst),
    .memen    (memen),
    .memwrite (memwrite),
    .addr     (addr),
    .wdata    (wdata),
    .flush    (flush),
    .rdata    (rdata),
    .stall    (stall),
    .req      (req),
    .wr       (wr),
    .size     (size),
    .baddr    (baddr),
    .bwdata   (bwdata),
    .bstrb    (bstrb),
    .addr_ok  (addr_ok),
    .data_ok  (data_ok),
    .brdata   (brdata)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full access: issue in cycle 0, addr_ok in REQ cycle ok_delay, data_ok gap cycles later.
  task automatic applyStimulus(input logic [3:0] strb, input logic [31:0] a, input logic [31:0] d,
                               input int ok_delay, input int gap, input logic [31:0] rd,
                               input logic [1:0] exp_size, input int exp_stalls,
                               input logic [31:0] exp_rdata);
    int stalls;
    int cyc;
    bit finished;
    tick;
    memen = 1'b1; memwrite = strb; addr = a; wdata = d;
    #1;
    stalls = stall ? 1 : 0;
    checkOutput("issue_req_low", {31'd0, req}, 32'd0);
    tick;
    memen = 1'b0; memwrite = 4'd0; addr = 32'hFFFF_FFFF; wdata = 32'h1234_5678;
    finished = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      cyc = i;
      addr_ok = (cyc == ok_delay);
      data_ok = (cyc == ok_delay + gap);
      brdata  = data_ok ? rd : 32'h0BAD_0BAD;
      #1;
      if (stall) stalls++;
      checkOutput("req_phase", {31'd0, req}, {31'd0, cyc <= ok_delay});
      if (cyc <= ok_delay) begin
        checkOutput("baddr_hold", baddr, a);
        checkOutput("bwdata_hold", bwdata, d);
        checkOutput("bstrb", {28'd0, bstrb}, {28'd0, strb});
        checkOutput("size", {30'd0, size}, {30'd0, exp_size});
        checkOutput("wr", {31'd0, wr}, {31'd0, |strb});
      end
      if (data_ok) begin
        finished = 1'b1;
        break;
      end
      tick;
    end
    checkOutput("access_finished", {31'd0, finished}, 32'd1);
    tick;
    addr_ok = 1'b0; data_ok = 1'b0; brdata = 32'd0;
    #1;
    checkOutput("done_stall_low", {31'd0, stall}, 32'd0);
    checkOutput("stall_cycles", stalls, exp_stalls);
    checkOutput("rdata", rdata, exp_rdata);
  endtask

  initial begin
    rst = 1'b0; memen = 1'b0; memwrite = 4'd0; addr = 32'd0; wdata = 32'd0; flush = 1'b0;
    addr_ok = 1'b0; data_ok = 1'b0; brdata = 32'd0;
    #1;
    checkOutput("rst_req", {31'd0, req}, 32'd0);
    checkOutput("rst_stall", {31'd0, stall}, 32'd0);
    checkOutput("rst_baddr", baddr, 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_size", {30'd0, size}, 32'd0);
    memen = 1'b1;
    #1;
    checkOutput("rst_stall_idle_eq", {31'd0, stall}, 32'd1);
    memen = 1'b0;
    tick;
    rst = 1'b1;

    // Load word, best case.
    applyStimulus(4'b0000, 32'h0000_0100, 32'd0, 1, 0, 32'hDEAD_BEEF, 2'd2, 2, 32'hDEAD_BEEF);
    // Store byte with delayed accept and data.
    applyStimulus(4'b0100, 32'h0000_0204, 32'h00AB_0000, 3, 2, 32'd0, 2'd0, 6, 32'hDEAD_BEEF);
    applyStimulus(4'b1100, 32'h0000_0302, 32'hBEEF_0000, 1, 0, 32'd0, 2'd1, 2, 32'hDEAD_BEEF);
    applyStimulus(4'b0110, 32'h0000_0400, 32'h00CC_DD00, 1, 1, 32'd0, 2'd2, 3, 32'hDEAD_BEEF);
    applyStimulus(4'b0011, 32'h0000_0500, 32'h0000_1122, 2, 0, 32'd0, 2'd1, 3, 32'hDEAD_BEEF);
    applyStimulus(4'b0001, 32'h0000_0603, 32'h0000_0077, 1, 0, 32'd0, 2'd0, 2, 32'hDEAD_BEEF);
    applyStimulus(4'b1111, 32'h0000_0700, 32'hA5A5_5A5A, 1, 0, 32'd0, 2'd2, 2, 32'hDEAD_BEEF);

    // Flush in the issue cycle: nothing goes out.
    tick;
    memen = 1'b1; flush = 1'b1; addr = 32'h0000_0800;
    #1;
    checkOutput("flush_idle_stall", {31'd0, stall}, 32'd0);
    tick;
    memen = 1'b0; flush = 1'b0;
    #1;
    checkOutput("flush_idle_req", {31'd0, req}, 32'd0);

    // Flush while waiting on a load: completes, returns to IDLE, rdata untouched.
    tick;
    memen = 1'b1; memwrite = 4'd0; addr = 32'h0000_0900;
    #1;
    tick;
    memen = 1'b0; addr_ok = 1'b1;
    #1;
    checkOutput("cancel_req", {31'd0, req}, 32'd1);
    tick;
    addr_ok = 1'b0; flush = 1'b1;
    #1;
    checkOutput("cancel_wait_stall", {31'd0, stall}, 32'd1);
    tick;
    flush = 1'b0; data_ok = 1'b1; brdata = 32'hCAFE_F00D;
    #1;
    tick;
    data_ok = 1'b0; brdata = 32'd0; memen = 1'b1; addr = 32'h0000_0A00;
    #1;
    checkOutput("cancel_back_in_idle", {31'd0, stall}, 32'd1);
    checkOutput("cancel_rdata_kept", rdata, 32'hDEAD_BEEF);
    tick;
    memen = 1'b0; addr_ok = 1'b1; data_ok = 1'b1; brdata = 32'h55AA_55AA;
    #1;
    checkOutput("after_cancel_req", {31'd0, req}, 32'd1);
    checkOutput("after_cancel_baddr", baddr, 32'h0000_0A00);
    tick;
    addr_ok = 1'b0; data_ok = 1'b0; memen = 1'b1; addr = 32'h0000_0B00;
    #1;
    checkOutput("done_rdata", rdata, 32'h55AA_55AA);
    checkOutput("done_no_issue", {31'd0, stall}, 32'd0);
    // Back-to-back: memen held through DONE, issue happens in the following IDLE cycle.
    tick;
    #1;
    checkOutput("b2b_idle_stall", {31'd0, stall}, 32'd1);
    checkOutput("b2b_idle_req", {31'd0, req}, 32'd0);
    tick;
    memen = 1'b0; addr_ok = 1'b1; data_ok = 1'b1; brdata = 32'h0102_0304;
    #1;
    checkOutput("b2b_req", {31'd0, req}, 32'd1);
    checkOutput("b2b_baddr", baddr, 32'h0000_0B00);
    tick;
    addr_ok = 1'b0; data_ok = 1'b0;
    #1;
    checkOutput("b2b_rdata", rdata, 32'h0102_0304);

    // Asynchronous reset while in WAIT on a store.
    tick;
    memen = 1'b1; memwrite = 4'b1111; addr = 32'h0000_0C00; wdata = 32'h7777_8888;
    #1;
    tick;
    memen = 1'b0; memwrite = 4'd0; addr_ok = 1'b1;
    #1;
    tick;
    addr_ok = 1'b0;
    #1;
    checkOutput("wait_stall", {31'd0, stall}, 32'd1);
    checkOutput("wait_wr", {31'd0, wr}, 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("arst_stall", {31'd0, stall}, 32'd0);
    checkOutput("arst_req", {31'd0, req}, 32'd0);
    checkOutput("arst_baddr", baddr, 32'd0);
    checkOutput("arst_bwdata", bwdata, 32'd0);
    checkOutput("arst_bstrb", {28'd0, bstrb}, 32'd0);
    checkOutput("arst_wr", {31'd0, wr}, 32'd0);
    checkOutput("arst_size", {30'd0, size}, 32'd0);
    checkOutput("arst_rdata", rdata, 32'd0);
    tick;
    rst = 1'b1;
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
